// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/request and result signals of the serial adder.
// The master side issues requests and the slave side (the adder) returns results.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum_out;
   logic             cout;
   logic             ovf;
   modport master (output start, op_a, op_b, cin, input busy, done, sum_out, cout, ovf);
   modport slave (input start, op_a, op_b, cin, output busy, done, sum_out, cout, ovf);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built on one Full_Adder cell, LSB first.
// Build option: define OVERFLOW_DET_EN to report signed overflow on ovf; otherwise ovf is 0.
module Full_Adder (
   input  logic a,
   input  logic b,
   input  logic d,
   output logic sum,
   output logic Carry
);
   assign sum   = a ^ b ^ d;
   assign Carry = (a & b) | (d & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic                clk,
   input logic                rst_n,
   serial_adder_ctrl_if.slave io_bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_count;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             w_sum;
   logic             w_carry;
   logic             w_last;
   logic [WIDTH-1:0] w_s_nxt;
   Full_Adder u_fa (
      .a     (r_a_sh[0]),
      .b     (r_b_sh[0]),
      .d     (r_carry),
      .sum   (w_sum),
      .Carry (w_carry)
   );
   // Partial sum fills from the MSB, so after WIDTH bits it is the full result.
   assign w_s_nxt = {w_sum, {(WIDTH-1){1'b0}}} | (r_s_sh >> 1);
   assign w_last  = r_count == CNT_W'(WIDTH - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_sum   <= '0;
         r_count <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (io_bus.start) begin
               r_a_sh  <= io_bus.op_a;
               r_b_sh  <= io_bus.op_b;
               r_carry <= io_bus.cin;
               r_count <= '0;
               r_s_sh  <= '0;
               r_busy  <= 1'b1;
               r_state <= RUN;
            end
            RUN: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_s_sh  <= w_s_nxt;
               r_carry <= w_carry;
               r_count <= r_count + CNT_W'(1);
               if (w_last) begin
                  r_sum   <= w_s_nxt;
                  r_cout  <= w_carry;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
`ifdef OVERFLOW_DET_EN
   // Carry into the MSB is the carry flop during the last RUN edge.
   logic r_ovf;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ovf <= 1'b0;
      else if (r_state == RUN && w_last) r_ovf <= r_carry ^ w_carry;
   end
   assign io_bus.ovf = r_ovf;
`else
   assign io_bus.ovf = 1'b0;
`endif
   assign io_bus.busy    = r_busy;
   assign io_bus.done    = r_done;
   assign io_bus.sum_out = r_sum;
   assign io_bus.cout    = r_cout;
endmodule
